// File: rtl/univ_reg_pkg.sv
// Shared encodings for the universal shift register and its command sequencer.
// Op codes double as the register's sel codes so the sequencer can pass them straight through.
package univ_reg_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

  function automatic logic is_shift_op(input logic [1:0] op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/univ_reg_seq_if.sv
// Command handshake between a command producer (master) and the sequencer (slave).
interface univ_reg_seq_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;
  logic             cmd_rot;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, cmd_rot,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, cmd_rot,
                  output cmd_ready);
endinterface

// File: rtl/univ_reg_seq_down_cnt.sv
// Loadable down-counter for the shift repeat count; saturates at zero.
module seq_down_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] val,
  output logic             is_zero,
  output logic             is_one
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)              cnt <= '0;
    else if (load)           cnt <= val;
    else if (dec && !is_zero) cnt <= cnt - 1'b1;
  end

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == CNT_W'(1));
endmodule

// File: rtl/univ_reg_seq.sv
// Command sequencer for the 4-bit universal shift register: turns one load/shift/hold
// command into the exact sel/din/lsi/rsi cycle sequence, then pulses done.
module univ_reg_seq
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  univ_reg_seq_if.slave    cmd,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] din,
  output logic             lsi,
  output logic             rsi,
  output logic             busy,
  output logic             done
);
  seq_state_t state;
  logic [1:0] op_q;
  logic       fill_q, rot_q;
  logic       accept, cnt_zero, cnt_one;
  logic       q_mid_unused;

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept        = (state == ST_IDLE) && cmd.cmd_valid;

  seq_down_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .dec     (state == ST_SHIFT),
    .val     (cmd.cmd_count),
    .is_zero (cnt_zero),
    .is_one  (cnt_one)
  );

  // Outputs are registered alongside the state so nothing from cmd_* reaches them combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      op_q   <= OP_HOLD;
      fill_q <= 1'b0;
      rot_q  <= 1'b0;
      sel    <= OP_HOLD;
      din    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cmd.cmd_valid) begin
          op_q   <= cmd.cmd_op;
          fill_q <= cmd.cmd_fill;
          rot_q  <= cmd.cmd_rot;
          busy   <= 1'b1;
          if (cmd.cmd_op == OP_LOAD) begin
            state <= ST_LOAD;
            sel   <= OP_LOAD;
            din   <= cmd.cmd_data;
          end else if (is_shift_op(cmd.cmd_op) && cmd.cmd_count != '0) begin
            state <= ST_SHIFT;
            sel   <= cmd.cmd_op;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_LOAD: begin
          state <= ST_DONE;
          sel   <= OP_HOLD;
          din   <= '0;
          done  <= 1'b1;
        end
        // A zero counter also exits so the FSM can never stall in SHIFT.
        ST_SHIFT: if (cnt_one || cnt_zero) begin
          state <= ST_DONE;
          sel   <= OP_HOLD;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Rotate feeds the end bit that is about to fall off back in at the other end.
  assign rsi = (state == ST_SHIFT) && (op_q == OP_SHR) && (rot_q ? q_in[0] : fill_q);
  assign lsi = (state == ST_SHIFT) && (op_q == OP_SHL) && (rot_q ? q_in[WIDTH-1] : fill_q);

  assign q_mid_unused = ^q_in;
endmodule

// File: tb/tb_univ_reg_seq.sv
// Scoreboard bench: driver pushes the expected outcome of each command, monitor pops on done.
module tb_univ_reg_seq;
  import univ_reg_pkg::*;
  localparam int W = 4, CW = 3;

  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] sel;
  logic [W-1:0] din, rq;
  logic lsi, rsi, busy, done;

  univ_reg_seq_if #(.WIDTH(W), .CNT_W(CW)) u_if ();

  univ_reg_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cmd(u_if), .q_in(rq),
    .sel(sel), .din(din), .lsi(lsi), .rsi(rsi), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Universal shift register sitting downstream, sharing the reset.
  always @(posedge clk) begin
    if (!reset) rq <= '0;
    else case (sel)
      OP_SHR:  rq <= {rsi, rq[W-1:1]};
      OP_SHL:  rq <= {rq[W-2:0], lsi};
      OP_LOAD: rq <= din;
      default: rq <= rq;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  typedef struct { int k; int q; int lat; int act; } exp_t;
  exp_t sbq[$];
  exp_t e_m;
  int model_q = 0;

  // Final register value of a shift command, from whole-word arithmetic.
  function automatic int ref_shift(int v, int op, int n, int fill, int rot);
    int mask = (1 << W) - 1;
    int m = n % W;
    if (op == 1) begin
      if (rot) return ((v >> m) | (v << (W - m))) & mask;
      return (v >> n) | (fill ? (mask & ~(mask >> n)) : 0);
    end
    if (rot) return ((v << m) | (v >> (W - m))) & mask;
    return ((v << n) & mask) | (fill ? (mask & ~(mask << n)) : 0);
  endfunction

  // Monitor: per-cycle output rules plus scoreboard pop on each done pulse.
  int act = 0;
  bit prev_done = 0;
  always @(negedge clk) begin
    if (!reset) begin
      act = 0;
      prev_done = 0;
    end else begin
      if (sel != OP_LOAD) chk("din_outside_load", din, 0);
      if (sel != OP_SHR)  chk("rsi_outside_shr", rsi, 0);
      if (sel != OP_SHL)  chk("lsi_outside_shl", lsi, 0);
      chk("ready_vs_busy", u_if.cmd_ready, !busy);
      if (prev_done) chk("busy_after_done", busy, 0);
      if (sel != OP_HOLD) act++;
      if (done) begin
        chk("done_sel_hold", sel, 0);
        chk("pending_cmd_at_done", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e_m = sbq.pop_front();
          chk("reg_value", rq, e_m.q);
          chk("done_latency", cyc - e_m.k, e_m.lat);
          chk("sel_active_cycles", act, e_m.act);
        end
        act = 0;
      end
      prev_done = done;
    end
  end

  task automatic rand_fields();
    u_if.cmd_op    = 2'($urandom_range(0, 3));
    u_if.cmd_data  = W'($urandom);
    u_if.cmd_count = CW'($urandom);
    u_if.cmd_fill  = 1'($urandom);
    u_if.cmd_rot   = 1'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge (or after the hold phase).
  task automatic issue(input int op, input int data, input int cnt, input int fill, input int rot,
                       input bit hold);
    int t = 0;
    exp_t e;
    while (!u_if.cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!u_if.cmd_ready) begin
      chk("ready_timeout", u_if.cmd_ready, 1);
      return;
    end
    u_if.cmd_op = 2'(op); u_if.cmd_data = W'(data); u_if.cmd_count = CW'(cnt);
    u_if.cmd_fill = 1'(fill); u_if.cmd_rot = 1'(rot); u_if.cmd_valid = 1'b1;
    e.k = cyc + 1;
    if (op == 3) begin
      e.q = data & ((1 << W) - 1); e.lat = 1; e.act = 1;
    end else if ((op == 1 || op == 2) && cnt > 0) begin
      e.q = ref_shift(model_q, op, cnt, fill, rot); e.lat = cnt; e.act = cnt;
    end else begin
      e.q = model_q; e.lat = 0; e.act = 0;
    end
    model_q = e.q;
    sbq.push_back(e);
    @(negedge clk);
    t = 0;
    while (hold && !u_if.cmd_ready && t < 60) begin
      rand_fields();
      @(negedge clk);
      t++;
    end
    u_if.cmd_valid = 1'b0;
  endtask

  initial begin
    int t;
    u_if.cmd_valid = 1'b0;
    rand_fields();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_din", din, 0);
    chk("rst_lsi", lsi, 0);
    chk("rst_rsi", rsi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", u_if.cmd_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    issue(3, 4'b1010, 0, 0, 0, 0);
    issue(3, 4'b0000, 0, 0, 0, 0);
    issue(1, 0, 3, 1, 0, 0);
    issue(3, 4'b1001, 0, 0, 0, 0);
    issue(2, 0, 1, 0, 1, 0);
    issue(1, 0, 2, 0, 1, 0);
    issue(2, 4'b0110, 0, 1, 0, 0);
    issue(0, 4'b0110, 5, 1, 1, 0);
    issue(1, 4'b0101, 5, 1, 0, 1);
    issue(2, 0, 7, 1, 0, 1);

    // Abort in the second cycle of a 4-shift.
    issue(1, 0, 4, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_sel", sel, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", u_if.cmd_ready, 1);
    chk("abort_reg", rq, 0);
    sbq.delete();
    model_q = 0;
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
    end

    t = 0;
    while (sbq.size() > 0 && t < 100) begin @(negedge clk); t++; end
    chk("scoreboard_drained", sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
